// File: rtl/st_arb_pkg.sv
// Shared types and round-robin helper for the three-channel stream arbiter.
package st_arb_pkg;

  localparam int NUM_CH = 3;

  typedef logic [1:0] chan_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic  hit;
    chan_t chan;
  } rr_grant_t;

  // Searches ptr+1, ptr+2, ptr (mod 3); first valid channel wins.
  function automatic rr_grant_t rr_next(input chan_t ptr, input logic [NUM_CH-1:0] valid);
    rr_grant_t res;
    chan_t     c;
    res = '0;
    c   = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (!res.hit && valid[c]) begin
        res.hit  = 1'b1;
        res.chan = c;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/st_out_reg.sv
// One-entry output holding register: loads on push, drains on out_ready.
module st_out_reg
  import st_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  chan_t             push_chan,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output chan_t             out_chan,
  output logic              out_valid,
  output logic              slot_free
);

  logic [DATA_W-1:0] data_q, data_d;
  chan_t             chan_q, chan_d;
  logic              valid_q, valid_d;

  assign slot_free = !valid_q | out_ready;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (push) begin
      data_d  = push_data;
      chan_d  = push_chan;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/st_rr_arbiter3.sv
// Three-input round-robin stream arbiter with bounded burst lock.
// Optional per-channel beat counters under ST_ARB_STATS_EN.
//   state | meaning
//   IDLE  | no lock; grant by round-robin from rr_ptr
//   BURST | owner holds the grant while valid, up to MAX_BURST beats
module st_rr_arbiter3
  import st_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ST_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_cnt0,
  output logic [15:0]       stat_cnt1,
  output logic [15:0]       stat_cnt2,
`endif
  input  logic [DATA_W-1:0] in0_data,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in0_valid,
  input  logic              in1_valid,
  input  logic              in2_valid,
  output logic              in0_ready,
  output logic              in1_ready,
  output logic              in2_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_chan,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [NUM_CH-1:0] vld_vec;
  arb_state_t        state_q, state_d;
  chan_t             owner_q, owner_d;
  chan_t             rr_ptr_q, rr_ptr_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]        cnt_inc;
  rr_grant_t         rr_g;
  logic              grant_hit;
  chan_t             grant_chan;
  logic              slot_free;
  logic              xfer;
  logic [DATA_W-1:0] push_data;

  assign vld_vec = {in2_valid, in1_valid, in0_valid};
  assign rr_g    = rr_next(rr_ptr_q, vld_vec);

  always_comb begin
    grant_hit  = rr_g.hit;
    grant_chan = rr_g.chan;
    if (state_q == BURST && vld_vec[owner_q]) begin
      grant_hit  = 1'b1;
      grant_chan = owner_q;
    end
  end

  assign xfer      = grant_hit & slot_free & !rst;
  assign in0_ready = xfer & (grant_chan == 2'd0);
  assign in1_ready = xfer & (grant_chan == 2'd1);
  assign in2_ready = xfer & (grant_chan == 2'd2);

  always_comb begin
    case (grant_chan)
      2'd1:    push_data = in1_data;
      2'd2:    push_data = in2_data;
      default: push_data = in0_data;
    endcase
  end

  assign cnt_inc = beat_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      if (state_q == BURST && grant_chan == owner_q) begin
        beat_cnt_d = cnt_inc;
        if (cnt_inc == 4'(MAX_BURST)) begin
          state_d    = IDLE;
          rr_ptr_d   = owner_q;
          beat_cnt_d = 4'd0;
        end
      end else if (MAX_BURST == 1) begin
        rr_ptr_d = grant_chan;
      end else begin
        // A takeover from a stalled owner passes priority on past the old owner.
        if (state_q == BURST) rr_ptr_d = owner_q;
        state_d    = BURST;
        owner_d    = grant_chan;
        beat_cnt_d = 4'd1;
      end
    end else if (slot_free && state_q == BURST) begin
      state_d    = IDLE;
      rr_ptr_d   = owner_q;
      beat_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      rr_ptr_q   <= 2'd2;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  st_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .push      (xfer),
    .push_data (push_data),
    .push_chan (grant_chan),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .slot_free (slot_free)
  );

`ifdef ST_ARB_STATS_EN
  logic [15:0] stat_q [NUM_CH];
  logic [15:0] stat_d [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr)
        stat_d[i] = 16'd0;
      else if (xfer && grant_chan == chan_t'(i) && stat_q[i] != 16'hFFFF)
        stat_d[i] = stat_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) stat_q[i] <= 16'd0;
      else     stat_q[i] <= stat_d[i];
    end
  end

  assign stat_cnt0 = stat_q[0];
  assign stat_cnt1 = stat_q[1];
  assign stat_cnt2 = stat_q[2];
`endif

endmodule
